// File: rtl/datapath_param.sv
// rtl/datapath_param.sv - parametrised single-bus CPU datapath with req/ack memory port
module datapath_param #(
  parameter  int DATA_W      = 32,
  parameter  int NUM_REGS    = 16,
  parameter  int ADDR_W      = 9,
  parameter  int MEM_TIMEOUT = 15,
  localparam int SRC_W       = $clog2(NUM_REGS + 8),
  localparam int SEL_W       = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [SRC_W-1:0]    src_sel,
  input  logic                ba_out,
  input  logic                reg_wr_en,
  input  logic [SEL_W-1:0]    reg_wr_sel,
  input  logic                hi_in,
  input  logic                lo_in,
  input  logic                y_in,
  input  logic                z_in,
  input  logic                pc_in,
  input  logic                mar_in,
  input  logic                mdr_in,
  input  logic                outport_in,
  input  logic                inc_pc,
  input  logic [DATA_W-1:0]   imm_c,
  input  logic [2*DATA_W-1:0] alu_result,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err_clr,
  input  logic [DATA_W-1:0]   inport_data,
  output logic [DATA_W-1:0]   bus_out,
  output logic [DATA_W-1:0]   y_out,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_busy,
  output logic                mem_err,
  output logic [DATA_W-1:0]   outport_data
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   hi, lo, y, pc, mdr, inport, outport;
  logic [2*DATA_W-1:0] z;
  // MAR is only ever observed as the memory address, so only those bits are kept
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   bus;

  logic [0:0]          state;
  logic [TO_W-1:0]     wait_cnt;

  logic is_idle, is_wait, start_ok, ack_done, timed_out, err_set, rd_capture;

  assign is_idle    = (state == S_IDLE);
  assign is_wait    = (state == S_WAIT);
  assign start_ok   = is_idle && (mem_rd ^ mem_wr);
  assign ack_done   = is_wait && mem_ack;
  // an ack arriving on the last allowed cycle still completes the transaction
  assign timed_out  = is_wait && !mem_ack && (wait_cnt == TO_LAST);
  assign err_set    = (is_idle && mem_rd && mem_wr) || (is_wait && (mem_rd || mem_wr)) || timed_out;
  assign rd_capture = ack_done && !mem_we;

  assign bus_out      = bus;
  assign y_out        = y;
  assign mem_req      = is_wait;
  assign mem_busy     = is_wait;
  assign mem_addr     = mar;
  assign mem_wdata    = mdr;
  assign outport_data = outport;

  // Encoded bus source mux: registers first, then the special sources
  always_comb begin
    bus = '0;
    if (int'(src_sel) < NUM_REGS) begin
      if (!(ba_out && (src_sel == '0))) bus = regs[src_sel[SEL_W-1:0]];
    end else begin
      case (int'(src_sel) - NUM_REGS)
        0:       bus = hi;
        1:       bus = lo;
        2:       bus = z[2*DATA_W-1:DATA_W];
        3:       bus = z[DATA_W-1:0];
        4:       bus = pc;
        5:       bus = mdr;
        6:       bus = inport;
        7:       bus = imm_c;
        default: bus = '0;
      endcase
    end
  end

  // General register file; R0 stores normally, masking happens on read
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_wr_en && (int'(reg_wr_sel) < NUM_REGS)) begin
      regs[reg_wr_sel] <= bus;
    end
  end

  // Special registers; MAR/MDR are frozen while a transaction is outstanding
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hi      <= '0;
      lo      <= '0;
      y       <= '0;
      z       <= '0;
      pc      <= '0;
      mar     <= '0;
      mdr     <= '0;
      inport  <= '0;
      outport <= '0;
    end else begin
      inport <= inport_data;
      if (hi_in)      hi      <= bus;
      if (lo_in)      lo      <= bus;
      if (y_in)       y       <= bus;
      if (z_in)       z       <= alu_result;
      if (outport_in) outport <= bus;
      if (pc_in)       pc <= bus;
      else if (inc_pc) pc <= pc + 1'b1;
      if (mar_in && is_idle) mar <= bus[ADDR_W-1:0];
      if (rd_capture)             mdr <= mem_rdata;
      else if (mdr_in && is_idle) mdr <= bus;
    end
  end

  // Memory transaction FSM with bounded wait for mem_ack
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      mem_we   <= 1'b0;
    end else if (start_ok) begin
      state    <= S_WAIT;
      wait_cnt <= '0;
      mem_we   <= mem_wr;
    end else if (ack_done || timed_out) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      mem_we   <= 1'b0;
    end else if (is_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky error flag; a new error in the clear cycle keeps it set
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)           mem_err <= 1'b0;
    else if (err_set)     mem_err <= 1'b1;
    else if (mem_err_clr) mem_err <= 1'b0;
  end

endmodule

// File: tb/tb_datapath_param.sv
// tb/tb_datapath_param.sv - directed scoreboard bench for datapath_param
module tb_datapath_param;

  localparam int DATA_W = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W = 9;
  localparam int MEM_TIMEOUT = 15;
  localparam int SRC_W = 5;
  localparam int SEL_W = 4;
  localparam int S_HI = 16, S_LO = 17, S_ZHI = 18, S_ZLO = 19;
  localparam int S_PC = 20, S_MDR = 21, S_IN = 22, S_IMM = 23;

  logic                clock = 1'b0;
  logic                clear;
  logic [SRC_W-1:0]    src_sel;
  logic                ba_out, reg_wr_en;
  logic [SEL_W-1:0]    reg_wr_sel;
  logic                hi_in, lo_in, y_in, z_in, pc_in, mar_in, mdr_in, outport_in, inc_pc;
  logic [DATA_W-1:0]   imm_c;
  logic [2*DATA_W-1:0] alu_result;
  logic                mem_rd, mem_wr, mem_ack, mem_err_clr;
  logic [DATA_W-1:0]   mem_rdata, inport_data;
  logic [DATA_W-1:0]   bus_out, y_out, mem_wdata, outport_data;
  logic                mem_req, mem_we, mem_busy, mem_err;
  logic [ADDR_W-1:0]   mem_addr;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb [$];
  int req_cnt, wait_cnt;
  logic err_early;

  datapath_param #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .clear(clear), .src_sel(src_sel), .ba_out(ba_out),
    .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel),
    .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in), .z_in(z_in), .pc_in(pc_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .outport_in(outport_in), .inc_pc(inc_pc),
    .imm_c(imm_c), .alu_result(alu_result),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_err_clr(mem_err_clr), .inport_data(inport_data),
    .bus_out(bus_out), .y_out(y_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
    .mem_err(mem_err), .outport_data(outport_data)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input int sel);
    logic [63:0] exp;
    src_sel = SRC_W'(sel);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, bus_out);
    end else begin
      exp = sb.pop_front();
      chk(tag, 64'(bus_out), exp);
    end
  endtask

  task automatic drive_imm(input logic [DATA_W-1:0] v);
    src_sel = SRC_W'(S_IMM);
    imm_c   = v;
  endtask

  initial begin
    clear = 1'b0; src_sel = '0; ba_out = 1'b0; reg_wr_en = 1'b0; reg_wr_sel = '0;
    hi_in = 0; lo_in = 0; y_in = 0; z_in = 0; pc_in = 0; mar_in = 0; mdr_in = 0;
    outport_in = 0; inc_pc = 0; imm_c = '0; alu_result = '0;
    mem_rd = 0; mem_wr = 0; mem_ack = 0; mem_rdata = '0; mem_err_clr = 0; inport_data = '0;
    tick; tick;
    clear = 1'b1;
    tick;

    // reset state
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(mem_busy), 64'd0);
    chk("rst_err", 64'(mem_err), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);

    // register file write/read and R0 masking
    drive_imm(32'hDEADBEEF); reg_wr_en = 1; reg_wr_sel = 4'd5; sb.push_back(64'hDEADBEEF);
    tick; reg_wr_en = 0;
    chk_bus("r5_read", 5);
    drive_imm(32'd7); reg_wr_en = 1; reg_wr_sel = 4'd0;
    tick; reg_wr_en = 0;
    ba_out = 1; sb.push_back(64'd0);
    chk_bus("r0_masked", 0);
    ba_out = 0; sb.push_back(64'd7);
    chk_bus("r0_stored", 0);

    // InPort is one cycle delayed
    inport_data = 32'h1234; sb.push_back(64'd0);
    chk_bus("inport_before", S_IN);
    tick; sb.push_back(64'h1234);
    chk_bus("inport_after", S_IN);

    // read transaction, ack in third WAIT cycle
    drive_imm(32'h012); mar_in = 1; tick; mar_in = 0;
    mem_rd = 1; sb.push_back(64'h55AA); tick; mem_rd = 0;
    req_cnt = 0;
    chk("rd_req", 64'(mem_req), 64'd1);
    chk("rd_we", 64'(mem_we), 64'd0);
    chk("rd_addr", 64'(mem_addr), 64'h012);
    if (mem_req) req_cnt++;
    drive_imm(32'h1FF); mar_in = 1; tick; mar_in = 0;
    chk("mar_hold_busy", 64'(mem_addr), 64'h012);
    if (mem_req) req_cnt++;
    tick;
    if (mem_req) req_cnt++;
    mem_ack = 1; mem_rdata = 32'h55AA; tick; mem_ack = 0; mem_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req) req_cnt++;
      tick;
    end
    chk("rd_req_cycles", 64'(req_cnt), 64'd3);
    chk("rd_busy_after", 64'(mem_busy), 64'd0);
    chk("rd_err", 64'(mem_err), 64'd0);
    chk_bus("rd_mdr", S_MDR);

    // write with no ack -> timeout
    drive_imm(32'hCAFE); mdr_in = 1; tick; mdr_in = 0;
    mem_wr = 1; tick; mem_wr = 0;
    chk("wr_we", 64'(mem_we), 64'd1);
    chk("wr_wdata", 64'(mem_wdata), 64'hCAFE);
    wait_cnt = 0; err_early = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_busy) break;
      wait_cnt++;
      if (mem_err) err_early = 1;
      tick;
    end
    chk("to_wait_cycles", 64'(wait_cnt), 64'd15);
    chk("to_err_early", 64'(err_early), 64'd0);
    chk("to_err", 64'(mem_err), 64'd1);
    chk("to_req", 64'(mem_req), 64'd0);
    chk("to_we", 64'(mem_we), 64'd0);
    sb.push_back(64'hCAFE);
    chk_bus("to_mdr_kept", S_MDR);
    mem_err_clr = 1; tick; mem_err_clr = 0;
    chk("to_err_clr", 64'(mem_err), 64'd0);

    // simultaneous rd+wr is illegal; set beats clear
    mem_rd = 1; mem_wr = 1; tick;
    chk("both_err", 64'(mem_err), 64'd1);
    chk("both_req", 64'(mem_req), 64'd0);
    chk("both_busy", 64'(mem_busy), 64'd0);
    mem_err_clr = 1; tick;
    chk("set_wins", 64'(mem_err), 64'd1);
    mem_rd = 0; mem_wr = 0; tick; mem_err_clr = 0;
    chk("clr_only", 64'(mem_err), 64'd0);

    // command while busy, then mdr_in on the ack cycle
    mem_rd = 1; sb.push_back(64'hA5A5); tick; mem_rd = 0;
    mem_wr = 1; tick; mem_wr = 0;
    chk("busy_cmd_err", 64'(mem_err), 64'd1);
    chk("busy_cmd_still", 64'(mem_busy), 64'd1);
    drive_imm(32'h7777); mdr_in = 1; mem_ack = 1; mem_rdata = 32'hA5A5;
    tick; mdr_in = 0; mem_ack = 0; mem_rdata = '0;
    chk("ack_done", 64'(mem_busy), 64'd0);
    chk_bus("mdr_mem_wins", S_MDR);
    mem_err_clr = 1; tick; mem_err_clr = 0;

    // PC wrap, pc_in priority, Z halves, HI/LO/Y/OutPort
    drive_imm(32'hFFFFFFFF); pc_in = 1; tick; pc_in = 0;
    inc_pc = 1; tick; inc_pc = 0; sb.push_back(64'd0);
    chk_bus("pc_wrap", S_PC);
    drive_imm(32'h40); pc_in = 1; inc_pc = 1; tick; pc_in = 0; inc_pc = 0;
    sb.push_back(64'h40);
    chk_bus("pc_in_wins", S_PC);
    alu_result = 64'h1_0000_0002; z_in = 1; tick; z_in = 0;
    sb.push_back(64'd1); chk_bus("z_hi", S_ZHI);
    sb.push_back(64'd2); chk_bus("z_lo", S_ZLO);
    drive_imm(32'h1357); y_in = 1; outport_in = 1; hi_in = 1; tick;
    y_in = 0; outport_in = 0; hi_in = 0;
    drive_imm(32'h2468); lo_in = 1; tick; lo_in = 0;
    chk("y_out", 64'(y_out), 64'h1357);
    chk("outport", 64'(outport_data), 64'h1357);
    sb.push_back(64'h1357); chk_bus("hi", S_HI);
    sb.push_back(64'h2468); chk_bus("lo", S_LO);

    // asynchronous reset in the middle of a WAIT
    imm_c = '0; inport_data = '0;
    mem_rd = 1; tick; mem_rd = 0;
    chk("pre_rst_busy", 64'(mem_busy), 64'd1);
    #2 clear = 1'b0;
    #1;
    chk("async_rst_req", 64'(mem_req), 64'd0);
    chk("async_rst_busy", 64'(mem_busy), 64'd0);
    tick;
    clear = 1'b1;
    tick;
    chk("rst_y", 64'(y_out), 64'd0);
    chk("rst_outport", 64'(outport_data), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    for (int s = 0; s < NUM_REGS + 8; s++) begin
      sb.push_back(64'd0);
      chk_bus($sformatf("rst_src%0d", s), s);
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
